rrf_commit_retire: RTL and testbench
====================================

Name: rrf_commit_retire

Overview:
In-order retirement engine on the commit side of the rename register file (RRF).
- Records each dispatched RRF entry's destination info and tracks execution completion per entry.
- Retires up to two finished entries per cycle, oldest first, starting at the commit pointer.
- Drives architectural writeback toward the ARF.
- Returns the retired count, which feeds the dispatch-side free-entry counter (`com_inst_num`).

Parameters:
- RRF_NUM, 64, number of RRF entries; tag 0 is reserved ("no rename") and never allocated or committed.
- RRF_SEL, 6, tag width = log2(RRF_NUM).
- ARF_SEL, 5, architectural register index width.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- dp_en_i  input  1  dispatch writes one RRF entry this cycle.
- dp_rrftag_i  input  RRF_SEL  tag being allocated.
- dp_dst_en_i  input  1  instruction writes an architectural register.
- dp_arf_idx_i  input  ARF_SEL  architectural destination index.
- exe_done0_i / exe_done1_i  input  1  execution completion strobes, two writeback ports.
- exe_rrftag0_i / exe_rrftag1_i  input  RRF_SEL  completed tags.
- com_stall_i  input  1  blocks all retirement this cycle.
- com_inst_num_o  output  2  number retired at last edge (0..2).
- com_en0_o / com_en1_o  output  1  commit slot valid (slot0 oldest).
- com_rrftag0_o / com_rrftag1_o  output  RRF_SEL  retired tags.
- com_dst_en0_o / com_dst_en1_o  output  1  ARF write enable per slot (com_enN_o AND stored dst_en).
- com_arf_idx0_o / com_arf_idx1_o  output  ARF_SEL  ARF destination per slot.
- comptr_o  output  RRF_SEL  current oldest uncommitted tag.
- rrf_empty_o  output  1  no entry allocated.

Behaviour:
- Per-entry state, entries 1..RRF_NUM-1:
  - valid bit, done bit, dst_en bit, arf_idx field.
  - Entry 0 storage tied off; writes to tag 0 are ignored.
- Reset (asynchronous, reset_i=0):
  - All valid/done bits cleared; comptr_o=1.
  - com_inst_num_o=0; all com_en*/com_dst_en* outputs 0; tags/indices 0; rrf_empty_o=1.
- Dispatch, dp_en_i=1 with tag T≠0: at the edge, valid[T]=1, done[T]=0, dst_en/arf_idx captured.
- Completion: exe_doneN_i with tag T sets done[T] at the edge only if valid[T] was 1 before that edge.
  - Completion to an invalid entry or to tag 0 is ignored.
  - Both ports naming the same tag is legal; done is set once.
- Commit decision (combinational on registered state, registered at the edge):
  - nxt(p) = (p == RRF_NUM-1) ? 1 : p+1.
  - c0 = !com_stall_i && valid[comptr] && done[comptr].
  - c1 = c0 && valid[nxt(comptr)] && done[nxt(comptr)].
- At the edge:
  - com_en0_o<=c0, com_en1_o<=c1; tags/arf fields captured from the selected entries.
  - com_inst_num_o<=c0+c1.
  - Committed entries get valid=0 and done=0.
  - comptr_o advances by c0+c1 with wrap through nxt; two steps may cross the wrap, e.g. 63→1→2.
- Outputs are single-cycle pulses; com_inst_num_o returns to 0 the cycle after with nothing to retire.
- Latency: exe_done at edge E sets done; earliest commit pulse is visible after edge E+1. No same-cycle bypass from exe_done to commit.
- Strict in-order retirement: slot1 never retires unless slot0 does.
- Simultaneous events on the same tag, same cycle:
  - Commit clear and dispatch set: dispatch wins, entry valid with done=0.
  - Dispatch and completion: dispatch wins, done=0.
- com_stall_i=1: no retirement and no pointer move; dispatch and completion still update state.
- rrf_empty_o = no valid bit set, registered (reflects state after each edge).
- Dispatch to an already-valid entry is an upstream protocol error:
  - Entry is overwritten.
  - A simulation-only assertion flags it.
- Reset mid-operation discards all entries immediately (asynchronous); outputs return to reset values without waiting for a clock.

Test Plan:
- Reset, then dispatch tags 1,2,3 (dst_en=1, arf 5,6,7), complete 1 and 2 in one cycle → next cycle com_en0/1=1, tags 1,2, arf 5,6, com_inst_num_o=2, comptr_o=3.
- Complete tag 3 before tag 2 (tags 1..3 valid, 1 done) → retire 1 only (num=1); then after 2 completes, 2 and 3 retire together (num=2).
- Pointer at 63, tags 63 and 1 valid+done → one edge retires both, comptr_o=2, tag 0 never appears on any commit port.
- com_stall_i=1 for 3 cycles with tags 1,2 done → com_inst_num_o=0, comptr_o=1 throughout; on release both retire in one cycle.
- Completion strobe for unallocated tag 9, then dispatch tag 9 → tag 9 not done; no commit until a real completion.
- Assert reset_i=0 asynchronously mid-retirement with com_en0_o=1 → outputs clear before the next edge, comptr_o=1, rrf_empty_o=1.

Source files
------------

// File: rtl/rrf_commit_retire_if.sv
// rtl/rrf_commit_retire_if.sv - dispatch/completion/commit bundle for the RRF retirement engine
interface rrf_commit_retire_if #(
  parameter int RRF_SEL = 6,
  parameter int ARF_SEL = 5
);
  logic               dp_en_i;
  logic [RRF_SEL-1:0] dp_rrftag_i;
  logic               dp_dst_en_i;
  logic [ARF_SEL-1:0] dp_arf_idx_i;
  logic               exe_done0_i;
  logic               exe_done1_i;
  logic [RRF_SEL-1:0] exe_rrftag0_i;
  logic [RRF_SEL-1:0] exe_rrftag1_i;
  logic               com_stall_i;
  logic [1:0]         com_inst_num_o;
  logic               com_en0_o;
  logic               com_en1_o;
  logic [RRF_SEL-1:0] com_rrftag0_o;
  logic [RRF_SEL-1:0] com_rrftag1_o;
  logic               com_dst_en0_o;
  logic               com_dst_en1_o;
  logic [ARF_SEL-1:0] com_arf_idx0_o;
  logic [ARF_SEL-1:0] com_arf_idx1_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic               rrf_empty_o;

  modport master (
    output dp_en_i, dp_rrftag_i, dp_dst_en_i, dp_arf_idx_i,
    output exe_done0_i, exe_done1_i, exe_rrftag0_i, exe_rrftag1_i, com_stall_i,
    input  com_inst_num_o, com_en0_o, com_en1_o, com_rrftag0_o, com_rrftag1_o,
    input  com_dst_en0_o, com_dst_en1_o, com_arf_idx0_o, com_arf_idx1_o,
    input  comptr_o, rrf_empty_o
  );

  modport slave (
    input  dp_en_i, dp_rrftag_i, dp_dst_en_i, dp_arf_idx_i,
    input  exe_done0_i, exe_done1_i, exe_rrftag0_i, exe_rrftag1_i, com_stall_i,
    output com_inst_num_o, com_en0_o, com_en1_o, com_rrftag0_o, com_rrftag1_o,
    output com_dst_en0_o, com_dst_en1_o, com_arf_idx0_o, com_arf_idx1_o,
    output comptr_o, rrf_empty_o
  );
endinterface

// File: rtl/rrf_commit_retire.sv
// rtl/rrf_commit_retire.sv - in-order two-wide retirement of RRF entries toward the ARF
module rrf_commit_retire #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6,
  parameter int ARF_SEL = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  rrf_commit_retire_if.slave bus
);

  logic [RRF_NUM-1:0] valid;
  logic [RRF_NUM-1:0] done;
  logic [RRF_NUM-1:0] dst_en;
  logic [RRF_NUM-1:0] valid_nxt;
  logic [RRF_NUM-1:0] done_nxt;
  logic [ARF_SEL-1:0] arf_idx [RRF_NUM];
  logic [RRF_SEL-1:0] comptr;
  logic [RRF_SEL-1:0] ptr1;
  logic [RRF_SEL-1:0] ptr2;
  logic               c0;
  logic               c1;
  logic               dp_wr;

  // Tag 0 means "no rename", so the pointer wraps from the last entry back to 1.
  function automatic logic [RRF_SEL-1:0] nxt(input logic [RRF_SEL-1:0] p);
    return (p == RRF_SEL'(RRF_NUM - 1)) ? RRF_SEL'(1) : p + RRF_SEL'(1);
  endfunction

  assign dp_wr = bus.dp_en_i && (bus.dp_rrftag_i != '0);

  // Retire decision from registered state only; no bypass from this cycle's completions.
  always_comb begin
    ptr1 = nxt(comptr);
    ptr2 = nxt(ptr1);
    c0   = !bus.com_stall_i && valid[comptr] && done[comptr];
    c1   = c0 && valid[ptr1] && done[ptr1];
  end

  // Next entry state: completion sets, commit clears, dispatch overrides both.
  always_comb begin
    valid_nxt = valid;
    done_nxt  = done;
    if (bus.exe_done0_i && valid[bus.exe_rrftag0_i]) done_nxt[bus.exe_rrftag0_i] = 1'b1;
    if (bus.exe_done1_i && valid[bus.exe_rrftag1_i]) done_nxt[bus.exe_rrftag1_i] = 1'b1;
    if (c0) begin
      valid_nxt[comptr] = 1'b0;
      done_nxt[comptr]  = 1'b0;
    end
    if (c1) begin
      valid_nxt[ptr1] = 1'b0;
      done_nxt[ptr1]  = 1'b0;
    end
    if (dp_wr) begin
      valid_nxt[bus.dp_rrftag_i] = 1'b1;
      done_nxt[bus.dp_rrftag_i]  = 1'b0;
    end
    valid_nxt[0] = 1'b0;
    done_nxt[0]  = 1'b0;
  end

  // Entry flags, commit pointer and registered commit outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid              <= '0;
      done               <= '0;
      dst_en             <= '0;
      comptr             <= RRF_SEL'(1);
      bus.com_inst_num_o <= 2'd0;
      bus.com_en0_o      <= 1'b0;
      bus.com_en1_o      <= 1'b0;
      bus.com_rrftag0_o  <= '0;
      bus.com_rrftag1_o  <= '0;
      bus.com_dst_en0_o  <= 1'b0;
      bus.com_dst_en1_o  <= 1'b0;
      bus.com_arf_idx0_o <= '0;
      bus.com_arf_idx1_o <= '0;
      bus.rrf_empty_o    <= 1'b1;
    end else begin
      valid <= valid_nxt;
      done  <= done_nxt;
      if (dp_wr) dst_en[bus.dp_rrftag_i] <= bus.dp_dst_en_i;
      comptr             <= c1 ? ptr2 : (c0 ? ptr1 : comptr);
      bus.com_inst_num_o <= c1 ? 2'd2 : (c0 ? 2'd1 : 2'd0);
      bus.com_en0_o      <= c0;
      bus.com_en1_o      <= c1;
      bus.com_rrftag0_o  <= c0 ? comptr : '0;
      bus.com_rrftag1_o  <= c1 ? ptr1 : '0;
      bus.com_dst_en0_o  <= c0 && dst_en[comptr];
      bus.com_dst_en1_o  <= c1 && dst_en[ptr1];
      bus.com_arf_idx0_o <= c0 ? arf_idx[comptr] : '0;
      bus.com_arf_idx1_o <= c1 ? arf_idx[ptr1] : '0;
      bus.rrf_empty_o    <= ~|valid_nxt;
    end
  end

  // Destination index payload; only read when the entry is valid, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (dp_wr) arf_idx[bus.dp_rrftag_i] <= bus.dp_arf_idx_i;
  end

  assign bus.comptr_o = comptr;

  // Upstream must never reallocate a tag that is still in flight.
  dp_overwrite_chk: assert property (@(posedge clk_i) disable iff (!reset_i)
    dp_wr |-> !valid[bus.dp_rrftag_i]);

endmodule

// File: tb/tb_rrf_commit_retire.sv
// tb/tb_rrf_commit_retire.sv - directed self-checking bench for rrf_commit_retire
module tb_rrf_commit_retire;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   retired_sum;

  rrf_commit_retire_if #(.RRF_SEL(6), .ARF_SEL(5)) bus ();

  rrf_commit_retire #(.RRF_NUM(64), .RRF_SEL(6), .ARF_SEL(5)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.dp_en_i       = 1'b0;
    bus.dp_rrftag_i   = '0;
    bus.dp_dst_en_i   = 1'b0;
    bus.dp_arf_idx_i  = '0;
    bus.exe_done0_i   = 1'b0;
    bus.exe_done1_i   = 1'b0;
    bus.exe_rrftag0_i = '0;
    bus.exe_rrftag1_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int t, input bit dst, input int arf);
    bus.dp_en_i      = 1'b1;
    bus.dp_rrftag_i  = 6'(t);
    bus.dp_dst_en_i  = dst;
    bus.dp_arf_idx_i = 5'(arf);
    tick();
    clr();
  endtask

  task automatic complete(input bit v0, input int t0, input bit v1, input int t1);
    bus.exe_done0_i   = v0;
    bus.exe_rrftag0_i = 6'(t0);
    bus.exe_done1_i   = v1;
    bus.exe_rrftag1_i = 6'(t1);
    tick();
    clr();
  endtask

  initial begin
    clr();
    bus.com_stall_i = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_num", bus.com_inst_num_o, 0);
    check("rst_en0", bus.com_en0_o, 0);
    check("rst_en1", bus.com_en1_o, 0);
    check("rst_comptr", bus.comptr_o, 1);
    check("rst_empty", bus.rrf_empty_o, 1);
    rst_n = 1'b1;

    // basic two-wide retire of 1,2
    dispatch(1, 1, 5);
    check("empty_after_dp", bus.rrf_empty_o, 0);
    dispatch(2, 1, 6);
    dispatch(3, 1, 7);
    complete(1, 1, 1, 2);
    check("no_bypass_en0", bus.com_en0_o, 0);
    tick();
    check("t1_en0", bus.com_en0_o, 1);
    check("t1_en1", bus.com_en1_o, 1);
    check("t1_tag0", bus.com_rrftag0_o, 1);
    check("t1_tag1", bus.com_rrftag1_o, 2);
    check("t1_arf0", bus.com_arf_idx0_o, 5);
    check("t1_arf1", bus.com_arf_idx1_o, 6);
    check("t1_dst0", bus.com_dst_en0_o, 1);
    check("t1_num", bus.com_inst_num_o, 2);
    check("t1_comptr", bus.comptr_o, 3);
    tick();
    check("t1_pulse_num", bus.com_inst_num_o, 0);
    check("t1_pulse_en0", bus.com_en0_o, 0);

    // out-of-order completion: 3 and 5 done, 4 pending
    dispatch(4, 1, 8);
    dispatch(5, 0, 9);
    complete(1, 3, 1, 5);
    tick();
    check("ooo_num1", bus.com_inst_num_o, 1);
    check("ooo_tag0", bus.com_rrftag0_o, 3);
    check("ooo_en1", bus.com_en1_o, 0);
    check("ooo_comptr", bus.comptr_o, 4);
    complete(1, 4, 0, 0);
    check("ooo_wait_num", bus.com_inst_num_o, 0);
    tick();
    check("ooo_num2", bus.com_inst_num_o, 2);
    check("ooo_tag0b", bus.com_rrftag0_o, 4);
    check("ooo_tag1b", bus.com_rrftag1_o, 5);
    check("ooo_dst1", bus.com_dst_en1_o, 0);
    check("ooo_arf0", bus.com_arf_idx0_o, 8);
    check("ooo_comptr2", bus.comptr_o, 6);
    check("ooo_empty", bus.rrf_empty_o, 1);

    // stall holds both ready entries for three cycles
    dispatch(6, 1, 10);
    dispatch(7, 1, 11);
    bus.com_stall_i = 1'b1;
    complete(1, 6, 1, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_num", bus.com_inst_num_o, 0);
      check("stall_comptr", bus.comptr_o, 6);
    end
    bus.com_stall_i = 1'b0;
    tick();
    check("stall_rel_num", bus.com_inst_num_o, 2);
    check("stall_rel_tag1", bus.com_rrftag1_o, 7);
    check("stall_rel_comptr", bus.comptr_o, 8);

    // completion to unallocated tag 9 is dropped
    bus.exe_done0_i   = 1'b1;
    bus.exe_rrftag0_i = 6'd9;
    dispatch(8, 1, 12);
    bus.exe_done0_i   = 1'b1;
    bus.exe_rrftag0_i = 6'd8;
    dispatch(9, 1, 13);
    tick();
    check("t9_num", bus.com_inst_num_o, 1);
    check("t9_tag0", bus.com_rrftag0_o, 8);
    check("t9_en1", bus.com_en1_o, 0);
    tick();
    check("t9_idle_num", bus.com_inst_num_o, 0);
    check("t9_comptr", bus.comptr_o, 9);
    complete(0, 0, 1, 9);
    tick();
    check("t9_retire_tag", bus.com_rrftag0_o, 9);
    check("t9_retire_comptr", bus.comptr_o, 10);

    // dispatch wins over simultaneous completion of the same tag
    bus.exe_done0_i   = 1'b1;
    bus.exe_rrftag0_i = 6'd10;
    dispatch(10, 1, 14);
    tick();
    tick();
    check("dpwin_num", bus.com_inst_num_o, 0);
    complete(1, 10, 0, 0);
    tick();
    check("dpwin_tag", bus.com_rrftag0_o, 10);
    check("dpwin_comptr", bus.comptr_o, 11);

    // walk the pointer to 63, counting retirements
    retired_sum = 0;
    for (int t = 11; t <= 62; t++) dispatch(t, 1, t % 32);
    for (int t = 11; t <= 62; t += 2) begin
      complete(1, t, 1, t + 1);
      retired_sum += int'(bus.com_inst_num_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      retired_sum += int'(bus.com_inst_num_o);
    end
    check("walk_retired", retired_sum, 52);
    check("walk_comptr", bus.comptr_o, 63);
    check("walk_empty", bus.rrf_empty_o, 1);

    // wrap 63 -> 1 -> 2 in one edge
    dispatch(63, 1, 3);
    dispatch(1, 1, 4);
    complete(1, 63, 1, 1);
    tick();
    check("wrap_num", bus.com_inst_num_o, 2);
    check("wrap_tag0", bus.com_rrftag0_o, 63);
    check("wrap_tag1", bus.com_rrftag1_o, 1);
    check("wrap_arf1", bus.com_arf_idx1_o, 4);
    check("wrap_comptr", bus.comptr_o, 2);

    // asynchronous reset in the middle of a commit pulse
    dispatch(2, 1, 1);
    dispatch(3, 1, 2);
    complete(1, 2, 1, 3);
    tick();
    check("ar_pre_en0", bus.com_en0_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_en0", bus.com_en0_o, 0);
    check("ar_num", bus.com_inst_num_o, 0);
    check("ar_tag0", bus.com_rrftag0_o, 0);
    check("ar_comptr", bus.comptr_o, 1);
    check("ar_empty", bus.rrf_empty_o, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_after_num", bus.com_inst_num_o, 0);
    check("ar_after_empty", bus.rrf_empty_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
